// File: rtl/eight_bit_sequential_divider_if.sv
// eight_bit_sequential_divider_if: valid/ready operand and result bundle; master drives operands, slave is the divider
interface eight_bit_sequential_divider_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/eight_bit_sequential_divider.sv
// eight_bit_sequential_divider: radix-2 restoring divider, clk/rst_n (async, active-low) plus operand/result handshake bus
module eight_bit_sequential_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input logic clk,
  input logic rst_n,
  eight_bit_sequential_divider_if.slave bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W-1:0]  pr;
  logic [DIVISOR_W-1:0]  dvs;
  logic [CNT_W-1:0]      cnt;
  logic                  dbz;
  logic [DIVISOR_W:0]    pr_sh;
  logic [DIVISOR_W-1:0]  pr_nxt;
  logic                  ge;
  logic                  accept;
  logic                  last;
  logic                  zero_div;
  assign accept   = bus.in_valid && bus.in_ready;
  assign zero_div = bus.divisor == '0;
  assign last     = cnt == CNT_W'(DIVIDEND_W - 1);
  // stored remainder is always below the divisor, so one extra bit covers the shifted value
  always_comb begin
    pr_sh  = {pr, q[DIVIDEND_W-1]};
    ge     = pr_sh >= {1'b0, dvs};
    pr_nxt = ge ? DIVISOR_W'(pr_sh - {1'b0, dvs}) : pr_sh[DIVISOR_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE && accept) ? (zero_div ? DONE : CALC) :
                (state == CALC && last) ? DONE :
                (state == DONE && bus.out_ready) ? IDLE : state;
  end
  always_comb begin
    bus.in_ready    = state == IDLE;
    bus.out_valid   = state == DONE;
    bus.quotient    = q;
    bus.remainder   = pr;
    bus.div_by_zero = dbz;
  end
  // a zero divisor loads the saturated result straight away instead of iterating
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q   <= '0;
      pr  <= '0;
      dvs <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      q   <= zero_div ? '1 : bus.dividend;
      pr  <= zero_div ? bus.dividend[DIVISOR_W-1:0] : '0;
      dvs <= bus.divisor;
      cnt <= '0;
      dbz <= zero_div;
    end else if (state == CALC) begin
      q   <= {q[DIVIDEND_W-2:0], ge};
      pr  <= pr_nxt;
      cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: doc/eight_bit_sequential_divider.md
Name: eight_bit_sequential_divider

Overview:
- Iterative radix-2 restoring divider. It is the inverse of the eight-bit Wallace-tree multiplier datapath.
- Takes a 16-bit unsigned product-width dividend and an 8-bit unsigned divisor. Returns the quotient and remainder after a fixed number of cycles.
- Sits beside the multiplier/accumulator tree. It checks or undoes accumulated products, e.g. normalising approximate MAC results by an operand.
- Valid/ready handshake on both input and output sides.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width in bits; also the number of iterations.
- DIVISOR_W, 8, divisor and remainder width in bits.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- dividend  input  DIVIDEND_W  unsigned dividend
- divisor  input  DIVISOR_W  unsigned divisor
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- quotient  output  DIVIDEND_W  unsigned quotient
- remainder  output  DIVISOR_W  unsigned remainder
- div_by_zero  output  1  result came from a zero divisor

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low.
- While rst_n is low, all state is cleared:
  - FSM = IDLE, in_ready=1, out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: latch dividend into the quotient/shift register and divisor into an internal register; clear the partial remainder (DIVISOR_W+1 bits) and the counter.
  - If divisor==0: go directly to DONE. At T+1: quotient=all ones, remainder=dividend[DIVISOR_W-1:0], div_by_zero=1.
  - Otherwise go to CALC, with div_by_zero=0.
- CALC:
  - in_ready=0.
  - Each cycle:
    - pr = {pr[DIVISOR_W-1:0], q_msb}
    - shift the quotient register left by 1
    - if pr >= divisor: pr -= divisor and quotient LSB = 1; else quotient LSB = 0.
  - The counter increments each cycle. After exactly DIVIDEND_W CALC cycles, go to DONE.
  - The remainder is always < divisor, so the final pr fits in DIVISOR_W bits.
- DONE:
  - out_valid=1 and in_ready=0.
  - quotient, remainder and div_by_zero are held stable until out_valid&&out_ready.
  - On that handshake edge: go to IDLE, out_valid drops, outputs keep their last values.
- Latency:
  - Nonzero divisor: out_valid first seen DIVIDEND_W+1 cycles after the accept edge (17 cycles at defaults).
  - Zero divisor: 1 cycle.
- Throughput:
  - No new accept in DONE (in_ready=0 there).
  - The earliest next accept is the cycle after the output handshake. Back-to-back operation costs DIVIDEND_W+2 cycles per result.
- Input changes while not in IDLE are ignored. Operands are sampled only at the accept edge.
- out_ready held high before DONE has no effect.
- Reset asserted mid-CALC or in DONE aborts the operation immediately and asynchronously. The result is lost, and no out_valid follows after release.
- Arithmetic identity, checked on every result with nonzero divisor:
  - dividend == quotient*divisor + remainder
  - remainder < divisor

Test Plan:
- Reset then dividend=1000, divisor=7, out_ready=1 -> out_valid exactly 17 cycles after accept; quotient=142, remainder=6, div_by_zero=0; in_ready returns 1 the following cycle.
- dividend=0xFFFF, divisor=0xFF -> quotient=257 (0x0101), remainder=0. Then dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0.
- dividend=200, divisor=255 -> quotient=0, remainder=200. Then dividend=0x1234, divisor=0 -> out_valid 1 cycle after accept, quotient=0xFFFF, remainder=0x34, div_by_zero=1.
- Back-pressure: 1000/7 with out_ready held low for 5 cycles after out_valid -> quotient/remainder stable and in_ready=0 throughout; in_valid pulses with new operands are ignored; the result clears on the first out_ready=1 edge.
- Reset mid-operation: assert rst_n=0 at CALC iteration 8 -> out_valid=0, in_ready=1 and all outputs 0 immediately. After release, a new 50/3 request yields quotient=16, remainder=2.
- Random sweep: 10,000 random operand pairs including 0 and all-ones -> every result satisfies the arithmetic identity; latency is 17 for nonzero divisors and 1 for zero.
